// File: rtl/neuron_mac.sv
// Sequential MAC for one neuron's pre-activation sum: bias seed, numInputs signed pairs, signed result.
// Latency: product registered on the accept edge, added on the next; sum_valid_o rises one edge after the last beat.
// Backpressure: in_ready_o only in ACCUM; result held in DONE until sum_ready_i. NEURON_MAC_SAT_EN selects clamped adds.
module neuron_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH  = 24,
  parameter int NUM_INPUTS = 784
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic signed [SUM_WIDTH-1:0]  bias_in_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic signed [DATA_WIDTH-1:0] data_in_i,
  input  logic signed [DATA_WIDTH-1:0] weight_in_i,
  output logic signed [SUM_WIDTH-1:0]  sum_out_o,
  output logic                         sum_valid_o,
  input  logic                         sum_ready_i,
  output logic                         busy_o
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  state_e                       state_q, state_d;
  logic signed [SUM_WIDTH-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0]     prod_q, prod_d;
  logic                         prod_vld_q, prod_vld_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic                         beat_acc;
  logic signed [PROD_W-1:0]     data_ext;
  logic signed [PROD_W-1:0]     weight_ext;
  logic signed [SUM_WIDTH-1:0]  prod_ext;
  logic signed [SUM_WIDTH-1:0]  acc_sum;

  // Operands widened to product width so the signed multiply keeps all bits.
  assign data_ext   = {{DATA_WIDTH{data_in_i[DATA_WIDTH-1]}}, data_in_i};
  assign weight_ext = {{DATA_WIDTH{weight_in_i[DATA_WIDTH-1]}}, weight_in_i};
  assign prod_ext   = {{(SUM_WIDTH - PROD_W){prod_q[PROD_W-1]}}, prod_q};

  assign beat_acc    = in_valid_i && (state_q == ACCUM);
  assign in_ready_o  = (state_q == ACCUM);
  assign sum_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  // Only expose the accumulator once it is final; zero otherwise.
  assign sum_out_o   = (state_q == DONE) ? acc_q : '0;

`ifdef NEURON_MAC_SAT_EN
  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};
  logic signed [SUM_WIDTH:0] acc_wide;

  // One guard bit exposes overflow; each add is clamped independently.
  always_comb begin
    acc_wide = {acc_q[SUM_WIDTH-1], acc_q} + {prod_ext[SUM_WIDTH-1], prod_ext};
    if (acc_wide[SUM_WIDTH] != acc_wide[SUM_WIDTH-1]) begin
      acc_sum = acc_wide[SUM_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      acc_sum = acc_wide[SUM_WIDTH-1:0];
    end
  end
`else
  // Two's-complement wrap modulo 2^SUM_WIDTH.
  assign acc_sum = acc_q + prod_ext;
`endif

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    prod_vld_d = prod_vld_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d      = bias_in_i;
          cnt_d      = '0;
          prod_vld_d = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_vld_q) begin
          acc_d = acc_sum;
        end
        if (beat_acc) begin
          prod_d     = data_ext * weight_ext;
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DRAIN;
          end
        end else begin
          prod_vld_d = 1'b0;
        end
      end
      DRAIN: begin
        // The final beat's product is still in flight; fold it in here.
        if (prod_vld_q) begin
          acc_d = acc_sum;
        end
        prod_vld_d = 1'b0;
        state_d    = DONE;
      end
      DONE: begin
        if (sum_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac with a four-pair evaluation: directed table, hand-written corner sequences, random runs.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected sums come from constants or from an integer reference of the bias-plus-products rule.
module tb_neuron_mac;
  localparam int DW = 8;
  localparam int SW = 24;
  localparam int NI = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [SW-1:0]        bias_in;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] weight_in;
  logic [SW-1:0]        sum_out;
  logic                 sum_valid;
  logic                 sum_ready;
  logic                 busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef logic [NI-1:0][DW-1:0] ops_t;
  typedef struct packed {
    logic [SW-1:0] bias;
    ops_t          d;
    ops_t          w;
    logic [3:0]    gap;
    logic [SW-1:0] exp;
  } vec_t;

`ifdef NEURON_MAC_SAT_EN
  localparam logic [SW-1:0] E_POS = 24'h7FFFFF;
  localparam logic [SW-1:0] E_NEG = 24'h800000;
  localparam logic [SW-1:0] E_BCK = 24'h7FC080;
`else
  localparam logic [SW-1:0] E_POS = 24'h80FB04;
  localparam logic [SW-1:0] E_NEG = 24'h7F0210;
  localparam logic [SW-1:0] E_BCK = 24'h7FFF72;
`endif

  always #5 clk = ~clk;

  neuron_mac #(
    .DATA_WIDTH(DW),
    .SUM_WIDTH (SW),
    .NUM_INPUTS(NI)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .bias_in_i  (bias_in),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .data_in_i  (data_in),
    .weight_in_i(weight_in),
    .sum_out_o  (sum_out),
    .sum_valid_o(sum_valid),
    .sum_ready_i(sum_ready),
    .busy_o     (busy)
  );

  function automatic ops_t pk(input int a, input int b, input int c, input int e);
    ops_t r;
    r[0] = 8'(a);
    r[1] = 8'(b);
    r[2] = 8'(c);
    r[3] = 8'(e);
    return r;
  endfunction

  // Reference: bias plus the sum of signed products, clamped after each add when saturating.
  function automatic logic [SW-1:0] ref_sum(input logic [SW-1:0] bias, input ops_t d, input ops_t w);
    longint s;
    longint lo;
    longint hi;
    lo = -(longint'(1) <<< (SW - 1));
    hi = (longint'(1) <<< (SW - 1)) - 1;
    s  = longint'($signed(bias));
    for (int i = 0; i < NI; i++) begin
      s = s + longint'($signed(d[i])) * longint'($signed(w[i]));
`ifdef NEURON_MAC_SAT_EN
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
`endif
    end
    return s[SW-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One full evaluation starting from IDLE at a falling edge; returns at the falling edge after the handshake.
  task automatic run_eval(input string tag, input logic [SW-1:0] bias, input ops_t d, input ops_t w,
                          input int gap, input int hold, input bit poke, input logic [SW-1:0] exp);
    start     = 1'b1;
    bias_in   = bias;
    in_valid  = 1'b0;
    sum_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start   = 1'b0;
    bias_in = 24'($urandom);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < NI; i++) begin
      in_valid  = 1'b1;
      data_in   = d[i];
      weight_in = w[i];
      @(negedge clk);
      in_valid  = 1'b0;
      data_in   = 8'($urandom);
      weight_in = 8'($urandom);
      if (i < NI - 1) begin
        for (int g = 0; g < gap; g++) begin
          check({tag, ".gap_rdy"}, 32'(in_ready), 32'd1);
          @(negedge clk);
        end
      end
    end
    sum_ready = 1'b0;
    check({tag, ".drain_vld"}, 32'(sum_valid), 32'd0);
    check({tag, ".drain_rdy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, ".valid"}, 32'(sum_valid), 32'd1);
    check({tag, ".sum"}, 32'(sum_out), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        start     = 1'b1;
        bias_in   = 24'h555555;
        in_valid  = 1'b1;
        data_in   = 8'sd127;
        weight_in = 8'sd127;
      end
      @(negedge clk);
      check({tag, ".hold_sum"}, 32'(sum_out), 32'(exp));
      check({tag, ".hold_vld"}, 32'(sum_valid), 32'd1);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".idle_vld"}, 32'(sum_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{bias: 24'h000100, d: pk(2, -1, 5, -7),       w: pk(3, 4, 5, 1),         gap: 4'd0, exp: 24'h000114};
    vecs[1] = '{bias: 24'h000100, d: pk(2, -1, 5, -7),       w: pk(3, 4, 5, 1),         gap: 4'd3, exp: 24'h000114};
    vecs[2] = '{bias: 24'h7FFF00, d: pk(127, 127, 127, 127), w: pk(127, 127, 127, 127), gap: 4'd0, exp: E_POS};
    vecs[3] = '{bias: 24'hFFFFF0, d: pk(0, 0, 0, 0),         w: pk(0, 0, 0, 0),         gap: 4'd1, exp: 24'hFFFFF0};
    vecs[4] = '{bias: 24'h000000, d: pk(-128, -128, -128, -128), w: pk(-128, -128, -128, -128), gap: 4'd0, exp: 24'h010000};
    vecs[5] = '{bias: 24'h800010, d: pk(-128, -128, -128, -128), w: pk(127, 127, 127, 127), gap: 4'd2, exp: E_NEG};
    vecs[6] = '{bias: 24'h7FFFF0, d: pk(127, -128, 1, 0),    w: pk(127, 127, 1, 0),     gap: 4'd0, exp: E_BCK};

    reset     = 1'b1;
    start     = 1'b0;
    bias_in   = '0;
    in_valid  = 1'b0;
    data_in   = '0;
    weight_in = '0;
    sum_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.sum_valid", 32'(sum_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.sum_out", 32'(sum_out), 32'd0);
    reset = 1'b0;
    // Inputs outside ACCUM must be ignored while idle.
    in_valid  = 1'b1;
    sum_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    sum_ready = 1'b0;
    check("idle.busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_eval($sformatf("vec%0d", i), vecs[i].bias, vecs[i].d, vecs[i].w,
               int'(vecs[i].gap), 0, 1'b0, vecs[i].exp);
    end

    // Result held with sum_ready low while start/in_valid are poked, then an immediate restart.
    run_eval("hold", 24'h000100, pk(2, -1, 5, -7), pk(3, 4, 5, 1), 0, 5, 1'b1, 24'h000114);
    run_eval("b2b", 24'h000010, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 0, 0, 1'b0, 24'h00001A);

    // Reset in the middle of accumulation, then a clean run shows no residue.
    start   = 1'b1;
    bias_in = 24'h123456;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      data_in   = 8'sd9;
      weight_in = 8'sd9;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("midrst.in_ready", 32'(in_ready), 32'd0);
    check("midrst.sum_valid", 32'(sum_valid), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.sum_out", 32'(sum_out), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("midrst.idle", 32'(busy), 32'd0);
    run_eval("postrst", 24'h000000, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0, 0, 1'b0, 24'h000004);

    // Reset while the result is waiting in DONE.
    start   = 1'b1;
    bias_in = 24'h000777;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid  = 1'b1;
      data_in   = 8'sd3;
      weight_in = 8'sd3;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("donerst.pre_vld", 32'(sum_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("donerst.sum_valid", 32'(sum_valid), 32'd0);
    check("donerst.sum_out", 32'(sum_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomized evaluations against the reference, with biases biased toward the limits.
    for (int r = 0; r < 40; r++) begin
      logic [SW-1:0] b;
      ops_t          d;
      ops_t          w;
      case ($urandom_range(0, 2))
        0:       b = 24'($urandom);
        1:       b = 24'h7FFF00 + 24'($urandom_range(0, 255));
        default: b = 24'h800000 + 24'($urandom_range(0, 255));
      endcase
      for (int k = 0; k < NI; k++) begin
        d[k] = 8'($urandom);
        w[k] = 8'($urandom);
      end
      run_eval($sformatf("rnd%0d", r), b, d, w, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ref_sum(b, d, w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
